// File: rtl/sel_demux_router.sv
// Registered 1-to-3 demultiplexer: routes handshaked input beats to alpha/beta/gamma
// one-entry output channels; undeliverable beats are consumed and counted as drops.
module sel_demux_router #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic             in_cs,
  input  logic [WIDTH-1:0] in_data,
  output logic             alpha_valid,
  input  logic             alpha_ready,
  output logic [WIDTH-1:0] alpha_data,
  output logic             beta_valid,
  input  logic             beta_ready,
  output logic [WIDTH-1:0] beta_data,
  output logic             gamma_valid,
  input  logic             gamma_ready,
  output logic [WIDTH-1:0] gamma_data,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned NCH = 3;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q [NCH];
  logic [0:0]       state_d [NCH];
  logic [WIDTH-1:0] data_q  [NCH];
  logic [NCH-1:0]   ch_ready;
  logic [NCH-1:0]   wr;
  logic             drop;
  logic             dst_busy;
  logic             accept;

  assign ch_ready = {gamma_ready, beta_ready, alpha_ready};

  // Routing: only a full, non-draining destination blocks the input.
  always_comb begin
    drop     = !in_cs || (in_sel == 2'b11);
    dst_busy = 1'b0;
    wr       = '0;
    case (in_sel)
      2'b00:   dst_busy = (state_q[0] == ST_FULL) && !alpha_ready;
      2'b01:   dst_busy = (state_q[1] == ST_FULL) && !beta_ready;
      2'b10:   dst_busy = (state_q[2] == ST_FULL) && !gamma_ready;
      default: dst_busy = 1'b0;
    endcase
    in_ready = drop || !dst_busy;
    accept   = in_valid && in_ready;
    for (int k = 0; k < NCH; k++) begin
      wr[k] = accept && !drop && (in_sel == 2'(k));
    end
  end

  // Per-channel next state; a write while draining keeps the channel full.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        ST_EMPTY: if (wr[k]) state_d[k] = ST_FULL;
        ST_FULL:  if (!wr[k] && ch_ready[k]) state_d[k] = ST_EMPTY;
        default:  state_d[k] = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < NCH; k++) state_q[k] <= ST_EMPTY;
    end else begin
      for (int k = 0; k < NCH; k++) state_q[k] <= state_d[k];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < NCH; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (wr[k]) data_q[k] <= in_data;
      end
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      drop_count <= '0;
    end else if (accept && drop && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

  assign alpha_valid = (state_q[0] == ST_FULL);
  assign beta_valid  = (state_q[1] == ST_FULL);
  assign gamma_valid = (state_q[2] == ST_FULL);
  assign alpha_data  = data_q[0];
  assign beta_data   = data_q[1];
  assign gamma_data  = data_q[2];

endmodule

// File: tb/tb_sel_demux_router.sv
// Scoreboard bench for sel_demux_router: directed beats push expected data per channel,
// a monitor pops and compares on every output transfer.
module tb_sel_demux_router;

  logic       clk = 1'b0;
  logic       nreset;
  logic       in_valid, in_ready, in_cs;
  logic [1:0] in_sel;
  logic [7:0] in_data;
  logic       alpha_valid, beta_valid, gamma_valid;
  logic       alpha_ready, beta_ready, gamma_ready;
  logic [7:0] alpha_data, beta_data, gamma_data;
  logic [1:0] drop_count;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] sb2[$];

  sel_demux_router #(.WIDTH(8), .CNT_W(2)) dut (
    .clk(clk), .nreset(nreset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_cs(in_cs), .in_data(in_data),
    .alpha_valid(alpha_valid), .alpha_ready(alpha_ready), .alpha_data(alpha_data),
    .beta_valid(beta_valid), .beta_ready(beta_ready), .beta_data(beta_data),
    .gamma_valid(gamma_valid), .gamma_ready(gamma_ready), .gamma_data(gamma_data),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    case (k)
      0: sb0.push_back(d);
      1: sb1.push_back(d);
      default: sb2.push_back(d);
    endcase
  endtask

  task automatic mon_ch(input int k, input logic v, input logic r, input logic [7:0] d);
    int n;
    logic [7:0] e;
    if (v && r) begin
      n = (k == 0) ? sb0.size() : (k == 1) ? sb1.size() : sb2.size();
      if (n == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ch%0d: got beat %0h required no beat", k, d);
      end else begin
        case (k)
          0: e = sb0.pop_front();
          1: e = sb1.pop_front();
          default: e = sb2.pop_front();
        endcase
        chk($sformatf("sb_ch%0d", k), 32'(d), 32'(e));
      end
    end
  endtask

  // Transfers complete on the next rising edge when valid and ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      if (nreset) begin
        mon_ch(0, alpha_valid, alpha_ready, alpha_data);
        mon_ch(1, beta_valid, beta_ready, beta_data);
        mon_ch(2, gamma_valid, gamma_ready, gamma_data);
      end
    end
  end

  function automatic logic ch_valid(input int k);
    return (k == 0) ? alpha_valid : (k == 1) ? beta_valid : gamma_valid;
  endfunction

  function automatic logic [7:0] ch_data(input int k);
    return (k == 0) ? alpha_data : (k == 1) ? beta_data : gamma_data;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a beat, waits for acceptance, then checks 1-cycle latency; leaves in_valid high.
  task automatic send(input logic [1:0] sel, input logic cs, input logic [7:0] d, input int exp_wait);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_sel = sel;
    in_cs = cs;
    in_data = d;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (exp_wait >= 0) chk("accept_wait", 32'(w), 32'(exp_wait));
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no accept in %0d cycles required accept", w);
      in_valid = 1'b0;
      return;
    end
    if (cs && sel != 2'b11) push(int'(sel), d);
    @(posedge clk);
    #1;
    if (cs && sel != 2'b11) begin
      chk("lat_valid", 32'(ch_valid(int'(sel))), 32'd1);
      chk("lat_data", 32'(ch_data(int'(sel))), 32'(d));
    end
  endtask

  initial begin
    nreset = 1'b0;
    in_valid = 1'b0; in_sel = 2'b00; in_cs = 1'b0; in_data = 8'h00;
    alpha_ready = 1'b1; beta_ready = 1'b1; gamma_ready = 1'b1;
    #2;
    chk("rst_valids", 32'({alpha_valid, beta_valid, gamma_valid}), 32'd0);
    chk("rst_datas", 32'({alpha_data, beta_data, gamma_data}), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    idle(1);

    // Back-to-back beats to each channel, all ready.
    send(2'b00, 1'b1, 8'hA1, 0);
    send(2'b01, 1'b1, 8'hB2, 0);
    chk("alpha_one_cycle", 32'(alpha_valid), 32'd0);
    send(2'b10, 1'b1, 8'hC3, 0);
    chk("beta_one_cycle", 32'(beta_valid), 32'd0);
    idle(1);
    chk("gamma_one_cycle", 32'(gamma_valid), 32'd0);
    chk("drop_zero", 32'(drop_count), 32'd0);

    // Stalled beta: second beat waits for beta_ready.
    beta_ready = 1'b0;
    send(2'b01, 1'b1, 8'h11, 0);
    in_data = 8'h22;
    @(negedge clk);
    chk("stall_ready0", 32'(in_ready), 32'd0);
    chk("stall_hold", 32'(beta_data), 32'h11);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_ready0b", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 beta_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 32'(in_ready), 32'd1);
    push(1, 8'h22);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("stall_next_valid", 32'(beta_valid), 32'd1);
    chk("stall_next_data", 32'(beta_data), 32'h22);
    idle(2);

    // Blocked beta does not stall a gamma beat.
    beta_ready = 1'b0;
    send(2'b01, 1'b1, 8'h33, 0);
    send(2'b10, 1'b1, 8'h5A, 0);
    chk("indep_beta_valid", 32'(beta_valid), 32'd1);
    chk("indep_beta_data", 32'(beta_data), 32'h33);
    in_valid = 1'b0;
    beta_ready = 1'b1;
    idle(2);

    // Drop beats: cs=0 and sel=11.
    send(2'b00, 1'b0, 8'hEE, 0);
    chk("drop1_valids", 32'({alpha_valid, beta_valid, gamma_valid}), 32'd0);
    chk("drop1_count", 32'(drop_count), 32'd1);
    send(2'b11, 1'b1, 8'hDD, 0);
    chk("drop2_valids", 32'({alpha_valid, beta_valid, gamma_valid}), 32'd0);
    chk("drop2_count", 32'(drop_count), 32'd2);
    idle(1);

    // Asynchronous reset with alpha held full.
    alpha_ready = 1'b0;
    send(2'b00, 1'b1, 8'h77, 0);
    in_valid = 1'b0;
    #2 nreset = 1'b0;
    sb0.delete();
    #1;
    chk("arst_alpha_valid", 32'(alpha_valid), 32'd0);
    chk("arst_alpha_data", 32'(alpha_data), 32'd0);
    chk("arst_drop", 32'(drop_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sel = 2'b00; in_cs = 1'b1; in_data = 8'h99;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_no_accept", 32'(alpha_valid), 32'd0);
    in_valid = 1'b0;
    nreset = 1'b1;
    send(2'b00, 1'b1, 8'h01, 0);
    in_valid = 1'b0;
    alpha_ready = 1'b1;
    idle(2);

    // Saturation of the 2-bit drop counter.
    for (int i = 0; i < 5; i++) begin
      send(2'b11, 1'b1, 8'(i), 0);
      chk($sformatf("sat_%0d", i), 32'(drop_count), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
    idle(3);
    chk("sb_empty", 32'(sb0.size() + sb1.size() + sb2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sel_demux_router.md
Name: sel_demux_router

Overview:
- Registered 1-to-3 demultiplexer; the distribution-side counterpart of the combinational alpha/beta/gamma select mux.
- Takes one handshaked input stream carrying a 2-bit select and a chip select, and routes each beat to the alpha, beta or gamma output channel.
- Each output channel has a one-entry holding register and a valid/ready handshake.
- Beats with no valid destination (cs=0 or sel=2'b11) are consumed and counted as drops.

Parameters:
- WIDTH, 8, data width of the input and of each output channel.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- nreset  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid=1.
- in_sel  input  2  destination: 00 alpha, 01 beta, 10 gamma, 11 none.
- in_cs  input  1  chip select; 0 means the beat has no destination.
- in_data  input  WIDTH  beat payload.
- alpha_valid, beta_valid, gamma_valid  output  1 each  channel holds a beat.
- alpha_ready, beta_ready, gamma_ready  input  1 each  downstream takes the beat.
- alpha_data, beta_data, gamma_data  output  WIDTH each  channel payload.
- drop_count  output  CNT_W  number of dropped beats, saturating.

Behaviour:
- Reset (nreset low, asynchronous):
  - All *_valid = 0, all *_data = 0, drop_count = 0.
  - in_ready follows the combinational rule below, evaluated with all channels EMPTY, so it is 1 during reset.
  - No beat is accepted while nreset is low.
  - Reset mid-operation discards held beats and the drop count with no partial outputs; normal operation resumes on the first clk edge after deassertion.
- Per-channel state machine (k = alpha/beta/gamma), two states:
  - EMPTY: k_valid=0.
  - FULL: k_valid=1, k_data stable.
  - EMPTY -> FULL on a write to k.
  - FULL -> EMPTY on k_ready=1 with no write to k in the same cycle.
  - FULL -> FULL with new data on k_ready=1 and a write to k in the same cycle. This pass-through gives full throughput.
  - FULL holds while k_ready=0.
- Routing and in_ready (combinational):
  - drop = (in_cs==0) or (in_sel==2'b11).
  - in_ready = drop OR NOT k_valid[sel] OR k_ready[sel].
  - A beat is accepted when in_valid AND in_ready.
  - On a non-drop accept, it is a write to channel sel: k_data <= in_data, and k_valid is 1 on the next cycle.
  - Latency in -> out is exactly 1 cycle.
  - A blocked channel stalls only beats addressed to it. Beats for other channels, and drop beats, are accepted in the same cycle.
- Drops:
  - On an accepted drop beat, drop_count <= drop_count + 1.
  - drop_count saturates at 2^CNT_W-1 and never wraps.
  - Dropped beats never assert any *_valid.
- Handshake rules:
  - Upstream holds in_valid, in_sel, in_cs and in_data stable until accepted.
  - This block holds k_valid and k_data stable until k_ready is sampled high.
  - k_valid never depends combinationally on k_ready.
- Independence: channels not addressed in a cycle are unaffected, except that their own ready drains them.

Test Plan:
- Reset then beats in_cs=1, sel=00/01/10 with data 8'hA1/8'hB2/8'hC3 on consecutive cycles, all ready=1 -> in_ready=1 throughout; alpha_data=A1, beta_data=B2 and gamma_data=C3, each valid for exactly 1 cycle, 1 cycle after its input; drop_count=0.
- beta_ready=0, two beats to sel=01 (8'h11, 8'h22) -> first is held (beta_data=11); in_ready=0 on the second until beta_ready=1; then beta_data=22 on the next cycle; no data lost or duplicated.
- beta channel stalled, plus a beat to sel=10 (8'h5A) -> accepted immediately; gamma_data=5A next cycle; beta holds unchanged.
- Beats with in_cs=0 (sel=00) and with in_cs=1, sel=11 -> both accepted in 1 cycle each; no *_valid asserted; drop_count=2.
- CNT_W=2, 5 drop beats -> drop_count sequence 1,2,3,3,3.
- alpha FULL with 8'h77 and alpha_ready=0; assert nreset=0 asynchronously between edges -> alpha_valid=0 and drop_count=0 immediately; after release, the first beat 8'h01 to alpha appears 1 cycle after acceptance.
